fp_sub_issue: RTL and testbench

- Sequential front end for the 64-bit combinational FP subtractor.
- Buffers operand pairs from the issuing unit in a small FIFO and presents the head pair to the subtractor.
- Overrides IEEE special cases (NaN, infinity) that the subtractor does not handle.
- Registers the result with a tag and status flags behind a valid/ready output handshake.

---
 rtl/fp_sub_issue_if.sv | 37 +++
 rtl/fp_sub_issue.sv | 148 ++++++++++++++
 tb/tb_fp_sub_issue.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_sub_issue_if.sv
// fp_sub_issue_if: request and result channels of the FP subtractor front end.
//
// Handshake rules, shared by both channels: a transfer happens on a rising
// clock edge where valid && ready are both high. A producer holding valid may
// not withdraw it or change its payload until the transfer happens. Ready may
// change freely while valid is low.
//
//   in_valid/in_ready/in_a/in_b/in_tag     request channel (issuer -> block)
//   out_valid/out_ready/out_result/
//   out_tag/out_flags                       result channel (block -> consumer)
//
// master: issuer/consumer side.  slave: the fp_sub_issue block.
interface fp_sub_issue_if #(
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      in_a;
    logic [63:0]      in_b;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_result;
    logic [TAG_W-1:0] out_tag;
    logic [3:0]       out_flags;

    modport master (
        output in_valid, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag, out_flags
    );

    modport slave (
        input  in_valid, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag, out_flags
    );
endinterface

// File: rtl/fp_sub_issue.sv
// fp_sub_issue: sequential front end for a 64-bit combinational FP subtractor.
//
// Operand pairs are buffered in a DEPTH-entry FIFO. The head pair is shown to
// the external subtractor (sub_a/sub_b); its answer (sub_result) is combined
// with NaN/infinity overrides and captured, with tag and flags, into a single
// output register behind the result handshake.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   bus (slave)     request and result channels, see fp_sub_issue_if
//   sub_a, sub_b    head minuend/subtrahend (0 when the FIFO is empty)
//   sub_result      combinational A-B from the subtractor
//   fifo_count      current FIFO occupancy
//
// out_flags = {invalid, inf, zero, bypass}.
module fp_sub_issue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    fp_sub_issue_if.slave            bus,
    output logic [63:0]              sub_a,
    output logic [63:0]              sub_b,
    input  logic [63:0]              sub_result,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

    // FIFO storage; contents need no reset because count gates every use.
    logic [63:0]      mem_a   [DEPTH];
    logic [63:0]      mem_b   [DEPTH];
    logic [TAG_W-1:0] mem_tag [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic             out_valid_q;
    logic [63:0]      out_result_q;
    logic [TAG_W-1:0] out_tag_q;
    logic [3:0]       out_flags_q;

    logic             in_ready;
    logic             push;
    logic             load;
    logic             empty;
    logic [TAG_W-1:0] head_tag;

    // in_ready depends on registered occupancy only, so there is no
    // combinational path from out_ready back to the issuer.
    assign empty    = (count == '0);
    assign in_ready = (count != FULL);
    assign push     = bus.in_valid && in_ready;
    assign load     = !empty && (!out_valid_q || bus.out_ready);

    assign sub_a    = empty ? '0 : mem_a[rd_ptr];
    assign sub_b    = empty ? '0 : mem_b[rd_ptr];
    assign head_tag = empty ? '0 : mem_tag[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr]   <= bus.in_a;
            mem_b[wr_ptr]   <= bus.in_b;
            mem_tag[wr_ptr] <= bus.in_tag;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two. A push and a
    // pop in the same cycle leave count unchanged; the pushed entry lands
    // behind the head and is never forwarded around it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (load) rd_ptr <= rd_ptr + AW'(1);
            case ({push, load})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Special-case selection on the head operands; first match wins.
    logic        a_nan, b_nan, a_inf, b_inf;
    logic [63:0] sel_result;
    logic        sel_invalid;
    logic        sel_bypass;
    logic        res_inf;
    logic        res_zero;

    always_comb begin
        a_nan       = (sub_a[62:52] == 11'h7FF) && (sub_a[51:0] != '0);
        b_nan       = (sub_b[62:52] == 11'h7FF) && (sub_b[51:0] != '0);
        a_inf       = (sub_a[62:52] == 11'h7FF) && (sub_a[51:0] == '0);
        b_inf       = (sub_b[62:52] == 11'h7FF) && (sub_b[51:0] == '0);
        sel_result  = sub_result;
        sel_invalid = 1'b0;
        sel_bypass  = 1'b1;
        if (a_nan || b_nan) begin
            sel_result  = QNAN;
            sel_invalid = 1'b1;
        end else if (a_inf && b_inf && (sub_a[63] == sub_b[63])) begin
            // inf - inf of the same sign has no defined value
            sel_result  = QNAN;
            sel_invalid = 1'b1;
        end else if (a_inf) begin
            sel_result  = sub_a;
        end else if (b_inf) begin
            // A - (+/-inf) = -/+inf
            sel_result  = {~sub_b[63], sub_b[62:0]};
        end else begin
            sel_bypass  = 1'b0;
        end
        res_inf  = (sel_result[62:52] == 11'h7FF) && (sel_result[51:0] == '0);
        res_zero = (sel_result[62:0] == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_tag_q    <= '0;
            out_flags_q  <= '0;
        end else if (load) begin
            out_valid_q  <= 1'b1;
            out_result_q <= sel_result;
            out_tag_q    <= head_tag;
            out_flags_q  <= {sel_invalid, res_inf, res_zero, sel_bypass};
        end else if (bus.out_ready) begin
            out_valid_q  <= 1'b0;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.out_tag    = out_tag_q;
    assign bus.out_flags  = out_flags_q;
    assign fifo_count     = count;
endmodule

// File: tb/tb_fp_sub_issue.sv
module tb_fp_sub_issue;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;
    localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fp_sub_issue_if #(.TAG_W(TAG_W)) bus ();
    logic [63:0] sub_a, sub_b, sub_result;
    logic [$clog2(DEPTH):0] fifo_count;

    // Stand-in for the combinational double-precision subtractor.
    assign sub_result = $realtobits($bitstoreal(sub_a) - $bitstoreal(sub_b));

    fp_sub_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .sub_a      (sub_a),
        .sub_b      (sub_b),
        .sub_result (sub_result),
        .fifo_count (fifo_count)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic is_nan(input logic [63:0] x);
        return (x[62:52] == 11'h7FF) && (x[51:0] != 0);
    endfunction

    function automatic logic is_inf(input logic [63:0] x);
        return (x[62:52] == 11'h7FF) && (x[51:0] == 0);
    endfunction

    // Returns {result[63:0], tag[3:0], flags[3:0]}.
    function automatic logic [71:0] model(input logic [63:0] a, input logic [63:0] b,
                                          input logic [TAG_W-1:0] tag);
        logic [63:0] r;
        logic inv, byp;
        inv = 1'b0;
        byp = 1'b1;
        if (is_nan(a) || is_nan(b)) begin
            r = QNAN; inv = 1'b1;
        end else if (is_inf(a) && is_inf(b) && a[63] == b[63]) begin
            r = QNAN; inv = 1'b1;
        end else if (is_inf(a)) begin
            r = a;
        end else if (is_inf(b)) begin
            r = b ^ 64'h8000_0000_0000_0000;
        end else begin
            r = $realtobits($bitstoreal(a) - $bitstoreal(b));
            byp = 1'b0;
        end
        return {r, tag, inv, is_inf(r), (r[62:0] == 0), byp};
    endfunction

    function automatic logic [63:0] rand_double();
        logic [63:0] x;
        case ($urandom_range(0, 9))
            0: x = {1'($urandom_range(0, 1)), 11'h7FF, 52'h0};
            1: x = {1'($urandom_range(0, 1)), 11'h7FF, 20'h0, 32'($urandom_range(1, 1000))};
            2: x = 64'h0;
            default: x = {1'($urandom_range(0, 1)), 11'($urandom_range(960, 1088)),
                          20'($urandom), 32'($urandom)};
        endcase
        return x;
    endfunction

    // ---------------- scoreboard ----------------
    logic [71:0] exp_q[$];
    logic [71:0] sb_e;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected", 1, 0);
                end else begin
                    sb_e = exp_q.pop_front();
                    check("sb_result", bus.out_result, sb_e[71:8]);
                    check("sb_tag", 64'(bus.out_tag), 64'(sb_e[7:4]));
                    check("sb_flags", 64'(bus.out_flags), 64'(sb_e[3:0]));
                end
            end
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(model(bus.in_a, bus.in_b, bus.in_tag));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [TAG_W-1:0] tag);
        int n;
        logic took;
        bus.in_valid = 1'b1;
        bus.in_a = a;
        bus.in_b = b;
        bus.in_tag = tag;
        n = 0;
        do begin
            took = bus.in_ready;
            @(posedge clk); #1;
            n++;
        end while (!took && n < 50);
        if (!took) check("push_timeout", 0, 1);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out();
        int n;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.out_valid) check("out_timeout", 0, 1);
    endtask

    // ---------------- directed tables ----------------
    localparam logic [63:0] SP_A [5] = '{64'h7FF0000000000000, 64'h3FF0000000000000,
        64'h7FF0000000000001, 64'h4000000000000000, 64'hFFF0000000000000};
    localparam logic [63:0] SP_B [5] = '{64'h7FF0000000000000, 64'hFFF0000000000000,
        64'h3FF0000000000000, 64'h4000000000000000, 64'h3FF0000000000000};
    localparam logic [63:0] SP_R [5] = '{64'h7FF8000000000000, 64'h7FF0000000000000,
        64'h7FF8000000000000, 64'h0000000000000000, 64'hFFF0000000000000};
    localparam logic [3:0] SP_F [5] = '{4'b1001, 4'b0101, 4'b1001, 4'b0010, 4'b0101};

    int acc;
    int vcnt;
    logic [63:0] ra, rb;
    logic [71:0] e_new;

    initial begin
        bus.in_valid = 1'b0;
        bus.in_a = '0;
        bus.in_b = '0;
        bus.in_tag = '0;
        bus.out_ready = 1'b1;

        // reset state
        #12;
        check("rst_out_valid", 64'(bus.out_valid), 0);
        check("rst_fifo_count", 64'(fifo_count), 0);
        check("rst_in_ready", 64'(bus.in_ready), 1);
        check("rst_out_result", bus.out_result, 0);
        check("rst_sub_a", sub_a, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // basic path with latency
        send(64'h3FF0000000000000, 64'h3FE0000000000000, 4'd3);
        check("lat_valid_early", 64'(bus.out_valid), 0);
        check("lat_count", 64'(fifo_count), 1);
        check("head_a", sub_a, 64'h3FF0000000000000);
        check("head_b", sub_b, 64'h3FE0000000000000);
        @(posedge clk); #1;
        check("basic_valid", 64'(bus.out_valid), 1);
        check("basic_result", bus.out_result, 64'h3FE0000000000000);
        check("basic_tag", 64'(bus.out_tag), 3);
        check("basic_flags", 64'(bus.out_flags), 0);
        check("empty_sub_a", sub_a, 0);
        @(posedge clk); #1;
        check("basic_drained", 64'(bus.out_valid), 0);

        // special cases and zero result
        for (int i = 0; i < 5; i++) begin
            send(SP_A[i], SP_B[i], 4'(i + 8));
            wait_out();
            check("sp_result", bus.out_result, SP_R[i]);
            check("sp_flags", 64'(bus.out_flags), 64'(SP_F[i]));
            check("sp_tag", 64'(bus.out_tag), 64'(i + 8));
            @(posedge clk); #1;
        end

        // backpressure / full
        bus.out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1'b1;
            bus.in_a = rand_double();
            bus.in_b = rand_double();
            bus.in_tag = 4'(i);
            if (bus.in_ready) acc++;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        check("bp_accepted", 64'(acc), 5);
        check("bp_in_ready", 64'(bus.in_ready), 0);
        check("bp_count", 64'(fifo_count), 4);
        repeat (3) @(posedge clk);
        #1;
        check("bp_hold_valid", 64'(bus.out_valid), 1);
        check("bp_hold_tag", 64'(bus.out_tag), 0);
        check("bp_hold_count", 64'(fifo_count), 4);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("drain_valid", 64'(bus.out_valid), 1);
            check("drain_tag", 64'(bus.out_tag), 64'(i));
            @(posedge clk); #1;
        end
        check("drain_done", 64'(bus.out_valid), 0);

        // streaming with pointer wrap
        vcnt = 0;
        for (int i = 0; i < 22; i++) begin
            if (i < 20) begin
                bus.in_valid = 1'b1;
                ra = rand_double();
                rb = ($urandom_range(0, 7) == 0) ? ra : rand_double();
                bus.in_a = ra;
                bus.in_b = rb;
                bus.in_tag = 4'(i % 16);
            end else begin
                bus.in_valid = 1'b0;
            end
            @(posedge clk); #1;
            if (bus.out_valid) vcnt++;
            check("stream_count_le1", 64'(fifo_count <= 1), 1);
        end
        check("stream_results", 64'(vcnt), 20);

        // reset mid-flight
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_a = rand_double();
            bus.in_b = rand_double();
            bus.in_tag = 4'(i + 4);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        check("pre_rst_count", 64'(fifo_count), 3);
        check("pre_rst_valid", 64'(bus.out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("mid_rst_valid", 64'(bus.out_valid), 0);
        check("mid_rst_count", 64'(fifo_count), 0);
        check("mid_rst_result", bus.out_result, 0);
        check("mid_rst_flags", 64'(bus.out_flags), 0);
        check("mid_rst_tag", 64'(bus.out_tag), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        e_new = model(64'h4008000000000000, 64'h3FF0000000000000, 4'd9);
        send(64'h4008000000000000, 64'h3FF0000000000000, 4'd9);
        wait_out();
        check("post_rst_tag", 64'(bus.out_tag), 9);
        check("post_rst_result", bus.out_result, 64'h4000000000000000);
        check("post_rst_model", bus.out_result, e_new[71:8]);
        @(posedge clk); #1;
        check("post_rst_no_stale", 64'(bus.out_valid), 0);
        check("post_rst_count", 64'(fifo_count), 0);

        repeat (3) @(posedge clk);
        #1;
        check("sb_leftover", 64'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
